// File: rtl/captura_pin.sv
`default_nettype none
// ============================================================================
// Module      : captura_pin
// Description : Keypad PIN-entry stage ahead of the gate controller.
//               Collects two BCD digits while a vehicle is present and
//               delivers them as an 8-bit Pin with a one-cycle Pin_valido
//               strobe. Handles clear, inactivity timeout and lock-out.
// Ports       : Clk            - clock, rising edge
//               Reset          - asynchronous, active-high reset
//               Vehiculo       - vehicle present at the gate
//               Bloqueo        - controller lock-out, entry disabled when high
//               Tecla[3:0]     - key code (0-9 digits, A-F non-digit)
//               Tecla_valida   - key strobe, rising edge = one key press
//               Borrar         - clear key (level)
//               Enviar         - enter key (level)
//               Pin[7:0]       - [7:4] first digit, [3:0] second digit
//               Pin_valido     - one-cycle pulse, Pin is new
//               Digitos[1:0]   - digits currently buffered (0..2)
//               Tecla_invalida - one-cycle pulse, non-digit key rejected
//               Timeout        - one-cycle pulse, partial entry discarded
// Revision    : 1.0 - initial release
// ============================================================================
module captura_pin #(
    parameter int TIMEOUT_CICLOS = 100,
    parameter int TO_W           = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Vehiculo,
    input  logic       Bloqueo,
    input  logic [3:0] Tecla,
    input  logic       Tecla_valida,
    input  logic       Borrar,
    input  logic       Enviar,
    output logic [7:0] Pin,
    output logic       Pin_valido,
    output logic [1:0] Digitos,
    output logic       Tecla_invalida,
    output logic       Timeout
);

    typedef enum logic [2:0] {
        INACTIVO = 3'd0,
        DIG0     = 3'd1,
        DIG1     = 3'd2,
        LLENO    = 3'd3,
        ENTREGA  = 3'd4
    } estado_t;

    localparam logic [TO_W-1:0] c_limite = TO_W'(TIMEOUT_CICLOS - 1);

    estado_t         r_estado;
    logic [7:0]      r_buffer;
    logic [TO_W-1:0] r_cnt;
    logic            r_tv_prev;

    logic w_pulsacion;
    logic w_es_digito;
    logic w_inactivo;
    logic w_expira;

    assign w_pulsacion = Tecla_valida & ~r_tv_prev;
    assign w_es_digito = (Tecla <= 4'd9);
    assign w_inactivo  = ~Vehiculo | Bloqueo;
    assign w_expira    = (r_cnt == c_limite);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_estado       <= INACTIVO;
            r_buffer       <= 8'h00;
            r_cnt          <= '0;
            r_tv_prev      <= 1'b0;
            Pin            <= 8'h00;
            Pin_valido     <= 1'b0;
            Digitos        <= 2'd0;
            Tecla_invalida <= 1'b0;
            Timeout        <= 1'b0;
        end else begin
            r_tv_prev      <= Tecla_valida;
            // Pulses default low so each lasts exactly one cycle.
            Pin_valido     <= 1'b0;
            Tecla_invalida <= 1'b0;
            Timeout        <= 1'b0;

            if (r_estado == ENTREGA) begin
                // Delivery completes even if the gate drops out this cycle;
                // only the next state is subject to the lock-out rule.
                Pin        <= r_buffer;
                Pin_valido <= 1'b1;
            end

            if (w_inactivo) begin
                r_estado <= INACTIVO;
                r_buffer <= 8'h00;
                r_cnt    <= '0;
                Digitos  <= 2'd0;
            end else begin
                case (r_estado)
                    INACTIVO: begin
                        r_cnt    <= '0;
                        r_estado <= DIG0;
                    end

                    DIG0: begin
                        r_cnt <= '0;
                        if (Borrar) begin
                            r_buffer <= 8'h00;
                            Digitos  <= 2'd0;
                        end else if (w_pulsacion && w_es_digito) begin
                            r_buffer[7:4] <= Tecla;
                            Digitos       <= 2'd1;
                            r_estado      <= DIG1;
                        end else if (w_pulsacion) begin
                            Tecla_invalida <= 1'b1;
                        end
                    end

                    DIG1, LLENO: begin
                        if (Borrar) begin
                            r_buffer <= 8'h00;
                            r_cnt    <= '0;
                            Digitos  <= 2'd0;
                            r_estado <= DIG0;
                        end else if (Enviar && r_estado == LLENO) begin
                            r_cnt    <= '0;
                            r_estado <= ENTREGA;
                        end else if (w_pulsacion && w_es_digito && r_estado == DIG1) begin
                            r_buffer[3:0] <= Tecla;
                            r_cnt         <= '0;
                            Digitos       <= 2'd2;
                            r_estado      <= LLENO;
                        end else begin
                            // Rejected key in DIG1 pulses but does not
                            // disturb the inactivity timer.
                            if (w_pulsacion && !w_es_digito && r_estado == DIG1)
                                Tecla_invalida <= 1'b1;
                            if (w_expira) begin
                                r_cnt    <= '0;
                                r_buffer <= 8'h00;
                                Digitos  <= 2'd0;
                                Timeout  <= 1'b1;
                                r_estado <= DIG0;
                            end else begin
                                r_cnt <= r_cnt + TO_W'(1);
                            end
                        end
                    end

                    ENTREGA: begin
                        r_buffer <= 8'h00;
                        r_cnt    <= '0;
                        Digitos  <= 2'd0;
                        r_estado <= DIG0;
                    end

                    default: begin
                        r_buffer <= 8'h00;
                        r_cnt    <= '0;
                        Digitos  <= 2'd0;
                        r_estado <= INACTIVO;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_captura_pin.sv
`default_nettype none
// ============================================================================
// Module      : tb_captura_pin
// Description : Self-checking bench for captura_pin. Cycle vectors with
//               hand-derived expected outputs, a timeout sequence and an
//               asynchronous reset sequence, compared through a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_captura_pin;

    localparam int TIMEOUT_CICLOS = 100;
    localparam int TO_W           = 8;
    localparam int N_VEC          = 42;

    logic       Clk          = 1'b0;
    logic       Reset        = 1'b1;
    logic       Vehiculo     = 1'b0;
    logic       Bloqueo      = 1'b0;
    logic [3:0] Tecla        = 4'h0;
    logic       Tecla_valida = 1'b0;
    logic       Borrar       = 1'b0;
    logic       Enviar       = 1'b0;
    logic [7:0] Pin;
    logic       Pin_valido;
    logic [1:0] Digitos;
    logic       Tecla_invalida;
    logic       Timeout;

    captura_pin #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
        .TO_W          (TO_W)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Vehiculo      (Vehiculo),
        .Bloqueo       (Bloqueo),
        .Tecla         (Tecla),
        .Tecla_valida  (Tecla_valida),
        .Borrar        (Borrar),
        .Enviar        (Enviar),
        .Pin           (Pin),
        .Pin_valido    (Pin_valido),
        .Digitos       (Digitos),
        .Tecla_invalida(Tecla_invalida),
        .Timeout       (Timeout)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       v;
        logic       b;
        logic [3:0] t;
        logic       tv;
        logic       bo;
        logic       en;
        logic [7:0] pin;
        logic       pv;
        logic [1:0] dig;
        logic       ti;
        logic       to;
    } vec_t;

    typedef struct {
        int          id;
        logic [12:0] exp;
    } sb_t;

    vec_t vecs [N_VEC];
    sb_t  sb [$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic v, input logic b, input logic [3:0] t,
                                input logic tv, input logic bo, input logic en,
                                input logic [7:0] pin, input logic pv,
                                input logic [1:0] dig, input logic ti, input logic to);
        vec_t r;
        r.v = v; r.b = b; r.t = t; r.tv = tv; r.bo = bo; r.en = en;
        r.pin = pin; r.pv = pv; r.dig = dig; r.ti = ti; r.to = to;
        return r;
    endfunction

    function automatic logic [12:0] pack_out(input logic [7:0] pin, input logic pv,
                                             input logic [1:0] dig, input logic ti,
                                             input logic to);
        return {pin, pv, dig, ti, to};
    endfunction

    task automatic esperar(input int id, input logic [12:0] exp);
        sb_t e;
        e.id  = id;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic comparar;
        sb_t         e;
        logic [12:0] got;
        got = pack_out(Pin, Pin_valido, Digitos, Tecla_invalida, Timeout);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h, expected an entry", got);
        end else begin
            e = sb.pop_front();
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL check_%0d: got pin=%h pv=%b dig=%0d ti=%b to=%b, expected pin=%h pv=%b dig=%0d ti=%b to=%b",
                         e.id, got[12:5], got[4], got[3:2], got[1], got[0],
                         e.exp[12:5], e.exp[4], e.exp[3:2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then compare the
    // outputs just after the following rising edge.
    task automatic ciclo(input vec_t x, input int id);
        @(negedge Clk);
        Vehiculo     = x.v;
        Bloqueo      = x.b;
        Tecla        = x.t;
        Tecla_valida = x.tv;
        Borrar       = x.bo;
        Enviar       = x.en;
        esperar(id, pack_out(x.pin, x.pv, x.dig, x.ti, x.to));
        @(posedge Clk);
        #1;
        comparar();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            v  b  t     tv bo en  pin    pv dig ti to
        // Entry of 4,2 then Enviar: Pin one cycle after the Enviar edge.
        vecs[0]  = mk(1, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 4'h4, 1, 0, 0, 8'h00, 0, 1, 0, 0);
        vecs[2]  = mk(1, 0, 4'h4, 0, 0, 0, 8'h00, 0, 1, 0, 0);
        vecs[3]  = mk(1, 0, 4'h2, 1, 0, 0, 8'h00, 0, 2, 0, 0);
        vecs[4]  = mk(1, 0, 4'h2, 0, 0, 0, 8'h00, 0, 2, 0, 0);
        vecs[5]  = mk(1, 0, 4'h0, 0, 0, 1, 8'h00, 0, 2, 0, 0);
        vecs[6]  = mk(1, 0, 4'h0, 0, 0, 0, 8'h42, 1, 0, 0, 0);
        vecs[7]  = mk(1, 0, 4'h0, 0, 0, 0, 8'h42, 0, 0, 0, 0);
        // Strobe held high five cycles: a single digit; then non-digit B.
        vecs[8]  = mk(1, 0, 4'h7, 1, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[9]  = mk(1, 0, 4'h7, 1, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[10] = mk(1, 0, 4'h7, 1, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[11] = mk(1, 0, 4'h7, 1, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[12] = mk(1, 0, 4'h7, 1, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[13] = mk(1, 0, 4'h7, 0, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[14] = mk(1, 0, 4'hB, 1, 0, 0, 8'h42, 0, 1, 1, 0);
        vecs[15] = mk(1, 0, 4'hB, 0, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[16] = mk(1, 0, 4'h0, 0, 1, 0, 8'h42, 0, 0, 0, 0);
        // 1,5 then Borrar+Enviar together: Borrar wins.
        vecs[17] = mk(1, 0, 4'h1, 1, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[18] = mk(1, 0, 4'h1, 0, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[19] = mk(1, 0, 4'h5, 1, 0, 0, 8'h42, 0, 2, 0, 0);
        vecs[20] = mk(1, 0, 4'h5, 0, 0, 0, 8'h42, 0, 2, 0, 0);
        vecs[21] = mk(1, 0, 4'h0, 0, 1, 1, 8'h42, 0, 0, 0, 0);
        vecs[22] = mk(1, 0, 4'h0, 0, 0, 0, 8'h42, 0, 0, 0, 0);
        // Enviar with only one digit is ignored.
        vecs[23] = mk(1, 0, 4'h6, 1, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[24] = mk(1, 0, 4'h6, 0, 0, 1, 8'h42, 0, 1, 0, 0);
        vecs[25] = mk(1, 0, 4'h6, 0, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[26] = mk(1, 0, 4'h0, 0, 1, 0, 8'h42, 0, 0, 0, 0);
        vecs[27] = mk(1, 0, 4'h0, 0, 0, 0, 8'h42, 0, 0, 0, 0);
        // Vehicle leaves mid-entry, then lock-out, then 0,8.
        vecs[28] = mk(1, 0, 4'h9, 1, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[29] = mk(0, 0, 4'h9, 0, 0, 0, 8'h42, 0, 0, 0, 0);
        vecs[30] = mk(1, 1, 4'h0, 0, 0, 0, 8'h42, 0, 0, 0, 0);
        vecs[31] = mk(1, 1, 4'h3, 1, 0, 0, 8'h42, 0, 0, 0, 0);
        vecs[32] = mk(1, 1, 4'h3, 0, 0, 0, 8'h42, 0, 0, 0, 0);
        vecs[33] = mk(1, 0, 4'h0, 0, 0, 0, 8'h42, 0, 0, 0, 0);
        vecs[34] = mk(1, 0, 4'h0, 1, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[35] = mk(1, 0, 4'h0, 0, 0, 0, 8'h42, 0, 1, 0, 0);
        vecs[36] = mk(1, 0, 4'h8, 1, 0, 0, 8'h42, 0, 2, 0, 0);
        vecs[37] = mk(1, 0, 4'h8, 0, 0, 1, 8'h42, 0, 2, 0, 0);
        vecs[38] = mk(1, 0, 4'h0, 0, 0, 0, 8'h08, 1, 0, 0, 0);
        vecs[39] = mk(1, 0, 4'h0, 0, 0, 0, 8'h08, 0, 0, 0, 0);
        // Non-digit key with an empty buffer.
        vecs[40] = mk(1, 0, 4'hA, 1, 0, 0, 8'h08, 0, 0, 1, 0);
        vecs[41] = mk(1, 0, 4'hA, 0, 0, 0, 8'h08, 0, 0, 0, 0);

        // Reset state, observed between clock edges while Reset is held.
        #12;
        esperar(0, 13'h0000);
        comparar();
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < N_VEC; i++)
            ciclo(vecs[i], 1 + i);

        // Inactivity timeout: pulse exactly TIMEOUT_CICLOS edges after the
        // edge that accepted the digit; Pin keeps its last value.
        ciclo(mk(1, 0, 4'h3, 1, 0, 0, 8'h08, 0, 1, 0, 0), 100);
        for (int k = 1; k <= TIMEOUT_CICLOS + 1; k++) begin
            if (k < TIMEOUT_CICLOS)
                ciclo(mk(1, 0, 4'h3, 0, 0, 0, 8'h08, 0, 1, 0, 0), 100 + k);
            else if (k == TIMEOUT_CICLOS)
                ciclo(mk(1, 0, 4'h3, 0, 0, 0, 8'h08, 0, 0, 0, 1), 100 + k);
            else
                ciclo(mk(1, 0, 4'h3, 0, 0, 0, 8'h08, 0, 0, 0, 0), 100 + k);
        end

        // Asynchronous reset mid-cycle while the buffer is full.
        ciclo(mk(1, 0, 4'h1, 1, 0, 0, 8'h08, 0, 1, 0, 0), 300);
        ciclo(mk(1, 0, 4'h1, 0, 0, 0, 8'h08, 0, 1, 0, 0), 301);
        ciclo(mk(1, 0, 4'h2, 1, 0, 0, 8'h08, 0, 2, 0, 0), 302);
        ciclo(mk(1, 0, 4'h2, 0, 0, 0, 8'h08, 0, 2, 0, 0), 303);
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        esperar(304, 13'h0000);
        comparar();
        @(negedge Clk);
        Reset = 1'b0;
        ciclo(mk(1, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 305);
        ciclo(mk(1, 0, 4'h5, 1, 0, 0, 8'h00, 0, 1, 0, 0), 306);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
